// File: rtl/piece_mover.sv
// -----------------------------------------------------------------------------
// piece_mover
//   Turns four raw push buttons into a bounded (x,y) piece position for the
//   VGA figure logic. A first press moves the piece immediately. Holding the
//   button starts auto-repeat after a delay, and repeats are aligned to the
//   prescaler tick. An optional gravity drop pushes the piece down
//   periodically. Every move reports a direction code, a one-cycle moved
//   pulse and, when the move hit a bound, a one-cycle blocked pulse.
//
// Ports
//   clk         in   1        system clock
//   rst         in   1        synchronous reset, active-high
//   up/down/left/right
//               in   1        raw buttons, asynchronous to clk
//   gravity_en  in   1        1 = periodic downward drop enabled
//   x, y        out  COORD_W  piece position
//   change      out  3        last move: 0 down, 1 up, 2 left, 3 right, 4 gravity
//   moved       out  1        one-cycle pulse when a move is applied
//   blocked     out  1        one-cycle pulse when that move was clamped
// -----------------------------------------------------------------------------
module piece_mover #(
    parameter int COORD_W     = 11,
    parameter int STEP        = 5,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = 635,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = 475,
    parameter int X_START     = 0,
    parameter int Y_START     = 0,
    parameter int TICK_DIV    = 2**23,
    parameter int REPEAT_DLY  = 4,
    parameter int REPEAT_RATE = 1,
    parameter int GRAV_TICKS  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               up,
    input  logic               down,
    input  logic               left,
    input  logic               right,
    input  logic               gravity_en,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic [2:0]         change,
    output logic               moved,
    output logic               blocked
);

    localparam int CW1     = COORD_W + 1;
    localparam int PRESC_W = $clog2(TICK_DIV);
    localparam int HOLD_W  = $clog2(REPEAT_DLY + 1);
    localparam int REP_W   = $clog2(REPEAT_RATE + 1);
    localparam int GRAV_W  = $clog2(GRAV_TICKS + 1);

    // Bounds and step widened by one bit so that +STEP cannot wrap
    // before it is compared against the bound.
    localparam logic [CW1-1:0] STEP_E  = CW1'(STEP);
    localparam logic [CW1-1:0] X_MIN_E = CW1'(X_MIN);
    localparam logic [CW1-1:0] X_MAX_E = CW1'(X_MAX);
    localparam logic [CW1-1:0] Y_MIN_E = CW1'(Y_MIN);
    localparam logic [CW1-1:0] Y_MAX_E = CW1'(Y_MAX);

    // Synchronised button vector layout: {right, left, down, up}.
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    localparam logic [2:0] CHG_DOWN  = 3'd0;
    localparam logic [2:0] CHG_UP    = 3'd1;
    localparam logic [2:0] CHG_LEFT  = 3'd2;
    localparam logic [2:0] CHG_RIGHT = 3'd3;
    localparam logic [2:0] CHG_GRAV  = 3'd4;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        REPEAT
    } state_t;

    typedef struct packed {
        logic               blk;
        logic [COORD_W-1:0] pos;
    } clamp_t;

    // Moves towards a larger coordinate, saturating at hi.
    function automatic clamp_t add_clamp(input logic [COORD_W-1:0] pos,
                                         input logic [CW1-1:0]     hi);
        clamp_t         res;
        logic [CW1-1:0] sum;
        sum = {1'b0, pos} + STEP_E;
        if (sum > hi) begin
            res.blk = 1'b1;
            res.pos = hi[COORD_W-1:0];
        end else begin
            res.blk = 1'b0;
            res.pos = sum[COORD_W-1:0];
        end
        return res;
    endfunction

    // Moves towards a smaller coordinate, saturating at lo. The test is done
    // before subtracting so the result never wraps below zero.
    function automatic clamp_t sub_clamp(input logic [COORD_W-1:0] pos,
                                         input logic [CW1-1:0]     lo);
        clamp_t res;
        if ({1'b0, pos} < lo + STEP_E) begin
            res.blk = 1'b1;
            res.pos = lo[COORD_W-1:0];
        end else begin
            res.blk = 1'b0;
            res.pos = pos - STEP_E[COORD_W-1:0];
        end
        return res;
    endfunction

    // ---------------------------------------------------------------- state
    logic [3:0]         btn_meta_q, btn_meta_d;
    logic [3:0]         btn_sync_q, btn_sync_d;
    logic [PRESC_W-1:0] presc_q,    presc_d;
    state_t             state_q,    state_d;
    logic [3:0]         dir_lat_q,  dir_lat_d;
    logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [REP_W-1:0]   rep_cnt_q,  rep_cnt_d;
    logic [GRAV_W-1:0]  grav_cnt_q, grav_cnt_d;
    logic [COORD_W-1:0] x_q,        x_d;
    logic [COORD_W-1:0] y_q,        y_d;
    logic [2:0]         change_q,   change_d;
    logic               moved_q,    moved_d;
    logic               blocked_q,  blocked_d;

    logic       tick;
    logic [3:0] dir;
    logic       dir_valid;
    logic       move_req;
    logic [3:0] move_dir;
    logic       grav_fire;
    clamp_t     x_inc, x_dec, y_inc, y_dec;

    // ------------------------------------------------- synchroniser, tick
    assign dir       = btn_sync_q;
    // Exactly one button down; chords and releases are not presses.
    assign dir_valid = (dir != 4'd0) && ((dir & (dir - 4'd1)) == 4'd0);
    assign tick      = (presc_q == PRESC_W'(TICK_DIV - 1));

    always_comb begin
        btn_meta_d = {right, left, down, up};
        btn_sync_d = btn_meta_q;
        presc_d    = tick ? '0 : presc_q + PRESC_W'(1);
    end

    // ------------------------------------------------------------- FSM
    // NOTE: every variable written here gets a default on entry, so no path
    // through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        dir_lat_d  = dir_lat_q;
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        move_req   = 1'b0;
        move_dir   = dir_lat_q;

        case (state_q)
            IDLE: begin
                if (dir_valid) begin
                    move_req   = 1'b1;
                    move_dir   = dir;
                    dir_lat_d  = dir;
                    hold_cnt_d = '0;
                    state_d    = HOLD;
                end
            end

            HOLD: begin
                // Any change of the button set (release, chord, other key)
                // drops back to IDLE; a new single key is taken from there.
                if (dir != dir_lat_q) begin
                    state_d = IDLE;
                end else if (tick) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    if (hold_cnt_d == HOLD_W'(REPEAT_DLY)) begin
                        move_req  = 1'b1;
                        rep_cnt_d = '0;
                        state_d   = REPEAT;
                    end
                end
            end

            REPEAT: begin
                if (dir != dir_lat_q) begin
                    state_d = IDLE;
                end else if (tick) begin
                    rep_cnt_d = rep_cnt_q + REP_W'(1);
                    if (rep_cnt_d == REP_W'(REPEAT_RATE)) begin
                        move_req  = 1'b1;
                        rep_cnt_d = '0;
                    end
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // --------------------------------------------------------- gravity
    // A gravity drop that coincides with a button move still clears the
    // counter; the position logic below gives the button priority, so the
    // drop is simply lost and the piece moves at most one STEP per cycle.
    always_comb begin
        grav_cnt_d = grav_cnt_q;
        grav_fire  = 1'b0;
        if (!gravity_en) begin
            grav_cnt_d = '0;
        end else if (tick) begin
            grav_cnt_d = grav_cnt_q + GRAV_W'(1);
            if (grav_cnt_d == GRAV_W'(GRAV_TICKS)) begin
                grav_fire  = 1'b1;
                grav_cnt_d = '0;
            end
        end
    end

    // -------------------------------------------------------- position
    assign x_inc = add_clamp(x_q, X_MAX_E);
    assign x_dec = sub_clamp(x_q, X_MIN_E);
    assign y_inc = add_clamp(y_q, Y_MAX_E);
    assign y_dec = sub_clamp(y_q, Y_MIN_E);

    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        change_d  = change_q;
        moved_d   = 1'b0;
        blocked_d = 1'b0;

        if (move_req) begin
            moved_d = 1'b1;
            case (move_dir)
                DIR_UP: begin
                    y_d       = y_dec.pos;
                    blocked_d = y_dec.blk;
                    change_d  = CHG_UP;
                end
                DIR_DOWN: begin
                    y_d       = y_inc.pos;
                    blocked_d = y_inc.blk;
                    change_d  = CHG_DOWN;
                end
                DIR_LEFT: begin
                    x_d       = x_dec.pos;
                    blocked_d = x_dec.blk;
                    change_d  = CHG_LEFT;
                end
                DIR_RIGHT: begin
                    x_d       = x_inc.pos;
                    blocked_d = x_inc.blk;
                    change_d  = CHG_RIGHT;
                end
                default: moved_d = 1'b0;
            endcase
        end else if (grav_fire) begin
            moved_d   = 1'b1;
            y_d       = y_inc.pos;
            blocked_d = y_inc.blk;
            change_d  = CHG_GRAV;
        end
    end

    // ------------------------------------------------------- registers
    // NOTE: state is only ever updated with non-blocking assignments so every
    // flop samples the values computed before the edge, independent of the
    // order the statements appear in.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            presc_q    <= '0;
            state_q    <= IDLE;
            dir_lat_q  <= '0;
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
            grav_cnt_q <= '0;
            x_q        <= COORD_W'(X_START);
            y_q        <= COORD_W'(Y_START);
            change_q   <= CHG_DOWN;
            moved_q    <= 1'b0;
            blocked_q  <= 1'b0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            presc_q    <= presc_d;
            state_q    <= state_d;
            dir_lat_q  <= dir_lat_d;
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
            grav_cnt_q <= grav_cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            change_q   <= change_d;
            moved_q    <= moved_d;
            blocked_q  <= blocked_d;
        end
    end

    assign x       = x_q;
    assign y       = y_q;
    assign change  = change_q;
    assign moved   = moved_q;
    assign blocked = blocked_q;

endmodule

// File: tb/tb_piece_mover.sv
// -----------------------------------------------------------------------------
// tb_piece_mover
//   Directed bench for piece_mover with a short tick (TICK_DIV=4,
//   REPEAT_DLY=2, REPEAT_RATE=1, GRAV_TICKS=3). A second instance starts
//   next to the bottom-right corner to exercise the bound clamps. Time is
//   tracked with cyc = edges since the last reset edge, so ticks land on
//   edges where cyc is a non-zero multiple of 4.
// -----------------------------------------------------------------------------
module tb_piece_mover;

    logic        clk = 1'b0;
    logic        rst;
    logic        up, down, left, right, gravity_en;
    logic [10:0] x, y;
    logic [2:0]  change;
    logic        moved, blocked;

    logic        b_down, b_right;
    logic [10:0] b_x, b_y;
    logic [2:0]  b_change;
    logic        b_moved, b_blocked;

    int cyc;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    piece_mover #(
        .COORD_W(11), .STEP(5),
        .X_MIN(0), .X_MAX(635), .Y_MIN(0), .Y_MAX(475),
        .X_START(0), .Y_START(0),
        .TICK_DIV(4), .REPEAT_DLY(2), .REPEAT_RATE(1), .GRAV_TICKS(3)
    ) dut (
        .clk(clk), .rst(rst),
        .up(up), .down(down), .left(left), .right(right),
        .gravity_en(gravity_en),
        .x(x), .y(y), .change(change), .moved(moved), .blocked(blocked)
    );

    piece_mover #(
        .COORD_W(11), .STEP(5),
        .X_MIN(0), .X_MAX(635), .Y_MIN(0), .Y_MAX(475),
        .X_START(635), .Y_START(473),
        .TICK_DIV(4), .REPEAT_DLY(2), .REPEAT_RATE(1), .GRAV_TICKS(3)
    ) dut_b (
        .clk(clk), .rst(rst),
        .up(1'b0), .down(b_down), .left(1'b0), .right(b_right),
        .gravity_en(1'b0),
        .x(b_x), .y(b_y), .change(b_change), .moved(b_moved), .blocked(b_blocked)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Advance until cyc % 4 == m.
    task automatic align(input int m);
        while (cyc % 4 != m) step(1);
    endtask

    // b: 0 down, 1 up, 2 left, 3 right
    task automatic set_btn(input int b, input logic v);
        case (b)
            0: down  = v;
            1: up    = v;
            2: left  = v;
            default: right = v;
        endcase
    endtask

    // One-clock raw pulse; returns on the edge where the move lands.
    task automatic tap(input int b);
        set_btn(b, 1'b1);
        step(1);
        set_btn(b, 1'b0);
        step(2);
    endtask

    task automatic tap_b(input int b);
        if (b == 0) b_down = 1'b1; else b_right = 1'b1;
        step(1);
        b_down  = 1'b0;
        b_right = 1'b0;
        step(2);
    endtask

    initial begin
        int moves;
        rst = 1'b1;
        {up, down, left, right, gravity_en, b_down, b_right} = '0;
        step(3);
        rst = 1'b0;

        // ---- reset state
        check("rst_x", x, 0);
        check("rst_y", y, 0);
        check("rst_change", change, 0);
        check("rst_moved", moved, 0);
        check("rst_blocked", blocked, 0);
        check("rst_b_x", b_x, 635);
        check("rst_b_y", b_y, 473);

        // ---- single right pulse, 3-clock latency, no repeat
        right = 1'b1;
        step(1);
        right = 1'b0;
        step(1);
        check("rpulse_x_early", x, 0);
        step(1);
        check("rpulse_x", x, 5);
        check("rpulse_change", change, 3);
        check("rpulse_moved", moved, 1);
        check("rpulse_blocked", blocked, 0);
        step(1);
        check("rpulse_moved_fall", moved, 0);
        step(12);
        check("rpulse_no_more", x, 5);

        // ---- bounds on the corner instance
        tap_b(0);
        check("b_down_y", b_y, 475);
        check("b_down_blocked", b_blocked, 1);
        check("b_down_moved", b_moved, 1);
        check("b_down_change", b_change, 0);
        step(1);
        check("b_blocked_fall", b_blocked, 0);
        tap_b(0);
        check("b_down2_y", b_y, 475);
        check("b_down2_blocked", b_blocked, 1);
        check("b_down2_moved", b_moved, 1);
        step(1);
        tap_b(3);
        check("b_right_x", b_x, 635);
        check("b_right_blocked", b_blocked, 1);
        check("b_right_change", b_change, 3);
        step(1);

        // ---- reach x=20 with three more taps
        repeat (3) begin
            tap(3);
            step(1);
        end
        check("tap_x20", x, 20);

        // ---- hold left from x=20; press at cyc=n with n%4==1
        align(1);
        left = 1'b1;
        step(3);                        // n+3
        check("hold_press_x", x, 15);
        check("hold_press_change", change, 2);
        check("hold_press_moved", moved, 1);
        step(1);                        // n+4
        check("hold_wait_moved", moved, 0);
        step(7);                        // n+11: second tick of HOLD
        check("hold_rep1_x", x, 10);
        check("hold_rep1_moved", moved, 1);
        step(3);                        // n+14
        check("hold_gap_x", x, 10);
        check("hold_gap_moved", moved, 0);
        step(1);                        // n+15
        check("hold_rep2_x", x, 5);
        step(4);                        // n+19
        check("hold_rep3_x", x, 0);
        check("hold_rep3_blocked", blocked, 0);
        check("hold_rep3_moved", moved, 1);
        step(4);                        // n+23
        check("hold_bound_x", x, 0);
        check("hold_bound_moved", moved, 1);
        check("hold_bound_blocked", blocked, 1);
        step(1);                        // n+24
        check("hold_bound_fall", blocked, 0);
        step(15);                       // n+39
        check("hold_bound2_blocked", blocked, 1);
        check("hold_bound2_x", x, 0);
        step(1);
        left = 1'b0;
        step(8);
        check("hold_release_x", x, 0);
        check("hold_release_moved", moved, 0);

        // ---- reach (50,50), then a two-button chord must not move
        repeat (10) begin
            tap(3);
            step(1);
        end
        repeat (10) begin
            tap(0);
            step(1);
        end
        check("chord_start_x", x, 50);
        check("chord_start_y", y, 50);
        up   = 1'b1;
        left = 1'b1;
        moves = 0;
        repeat (20) begin
            step(1);
            if (moved === 1'b1) moves++;
        end
        check("chord_moves", moves, 0);
        check("chord_x", x, 50);
        check("chord_y", y, 50);
        up   = 1'b0;
        left = 1'b0;
        step(4);

        // ---- gravity from y=0: drops at cyc 12, 24, 36
        rst        = 1'b1;
        gravity_en = 1'b1;
        step(2);
        rst = 1'b0;
        check("grav_rst_x", x, 0);
        check("grav_rst_y", y, 0);
        step(11);                       // 11
        check("grav_pre_y", y, 0);
        step(1);                        // 12
        check("grav1_y", y, 5);
        check("grav1_change", change, 4);
        check("grav1_moved", moved, 1);
        check("grav1_blocked", blocked, 0);
        step(1);                        // 13
        check("grav1_moved_fall", moved, 0);
        step(11);                       // 24
        check("grav2_y", y, 10);
        step(12);                       // 36
        check("grav3_y", y, 15);
        check("grav3_change", change, 4);
        // Down press whose move lands on the gravity edge at cyc 48.
        step(9);                        // 45
        down = 1'b1;
        step(1);                        // 46
        down = 1'b0;
        step(2);                        // 48
        check("grav_btn_y", y, 20);
        check("grav_btn_change", change, 0);
        check("grav_btn_moved", moved, 1);
        step(1);                        // 49
        check("grav_btn_single", y, 20);
        step(11);                       // 60: counter restarted at 48
        check("grav4_y", y, 25);
        check("grav4_change", change, 4);
        gravity_en = 1'b0;
        step(30);
        check("grav_off_y", y, 25);

        // ---- reset during REPEAT with right still held
        align(1);
        right = 1'b1;
        step(12);                       // n+12: past first repeat at n+11
        check("rrep_x", x, 10);
        rst = 1'b1;
        step(1);
        check("rrep_rst_x", x, 0);
        check("rrep_rst_moved", moved, 0);
        check("rrep_rst_y", y, 0);
        rst = 1'b0;
        step(2);
        check("rrep_refill_x", x, 0);
        step(1);
        check("rrep_again_x", x, 5);
        check("rrep_again_change", change, 3);
        check("rrep_again_moved", moved, 1);
        right = 1'b0;
        step(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
